load_store_unit: RTL

Multi-cycle data-memory access unit sitting directly downstream of the core's execute stage. It accepts one LDR/STR request per transaction: the effective address comes from the ALU result and the store data from the register file. It runs a req/ack handshake on the data-memory bus, steers byte lanes for byte and word accesses, and returns load data as a single-cycle write-back pulse. While a transaction is in flight it holds the core in a stall.

---
 rtl/feather_pkg.sv | 17 +
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/feather_pkg.sv
// Shared definitions for the feather core data-memory path.
// Provides the load/store unit FSM state type, data-bus width constants and
// the all-lanes byte-enable pattern used for word accesses.
package feather_pkg;

  localparam int XLEN = 32;        // data bus width in bits
  localparam int BE_W = XLEN / 8;  // byte lanes on the data bus

  localparam logic [BE_W-1:0] WORD_BE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane steering for the load/store unit (combinational).
// Ports:
//   addr       - low two bits of the effective byte address
//   is_byte    - 1 = byte access, 0 = word access
//   store_data - register value to be written
//   rdata      - raw word returned by the bus
//   be         - byte enables for the bus cycle
//   wdata      - store data replicated onto the lanes
//   load_data  - zero-extended load result taken from rdata
module lsu_lane_align
  import feather_pkg::*;
(
  input  logic [1:0]      addr,
  input  logic            is_byte,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [BE_W-1:0][7:0] rd_lanes;
  assign rd_lanes = rdata;

  always_comb begin
    if (is_byte) begin
      be        = {{(BE_W-1){1'b0}}, 1'b1} << addr;
      // Replicating the byte onto every lane lets the memory pick it up
      // from whichever lane the enable selects.
      wdata     = {BE_W{store_data[7:0]}};
      load_data = {{(XLEN-8){1'b0}}, rd_lanes[addr]};
    end else begin
      be        = WORD_BE;
      wdata     = store_data;
      load_data = rdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle LDR/STR data-memory access unit.
// Accepts one request in IDLE, runs a req/ack handshake on the data bus
// (REQ), and returns load data as a single-cycle write-back strobe (WB).
// Misaligned word accesses and bus timeouts raise a one-cycle fault.
// Ports:
//   clk, reset_i                 - clock, synchronous active-high reset
//   start_i, load_i, byte_i      - request strobe and access type
//   address_i, store_data_i      - effective address, store source value
//   dest_reg_i                   - load destination register
//   busy_o                       - core stall while a transaction is in flight
//   wb_valid_o/wb_reg_o/wb_data_o - load write-back (registered)
//   fault_o                      - misalignment / timeout pulse (registered)
//   mem_*                        - data-memory bus
module load_store_unit
  import feather_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            load_i,
  input  logic            byte_i,
  input  logic [XLEN-1:0] address_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [3:0]      dest_reg_i,
  output logic            busy_o,
  output logic            wb_valid_o,
  output logic [3:0]      wb_reg_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            fault_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i
);

  // Counter value seen in the last REQ cycle allowed to wait for ack.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  lsu_state_t      state;
  logic [7:0]      tmo_cnt;
  logic            is_load_q;
  logic            is_byte_q;
  logic [1:0]      lane_q;
  logic [3:0]      dest_q;

  logic [BE_W-1:0] req_be;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] rsp_load;
  logic [XLEN-1:0] unused_req_load;
  logic [BE_W-1:0] unused_rsp_be;
  logic [XLEN-1:0] unused_rsp_wdata;

  // Request side: steer the incoming store onto the lanes.
  lsu_lane_align u_req_align (
    .addr       (address_i[1:0]),
    .is_byte    (byte_i),
    .store_data (store_data_i),
    .rdata      ('0),
    .be         (req_be),
    .wdata      (req_wdata),
    .load_data  (unused_req_load)
  );

  // Response side: extract the load from the lane latched at start.
  lsu_lane_align u_rsp_align (
    .addr       (lane_q),
    .is_byte    (is_byte_q),
    .store_data ('0),
    .rdata      (mem_rdata_i),
    .be         (unused_rsp_be),
    .wdata      (unused_rsp_wdata),
    .load_data  (rsp_load)
  );

  assign busy_o    = (state != IDLE);
  assign mem_req_o = (state == REQ);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      is_load_q   <= 1'b0;
      is_byte_q   <= 1'b0;
      lane_q      <= '0;
      dest_q      <= '0;
      wb_valid_o  <= 1'b0;
      wb_reg_o    <= '0;
      wb_data_o   <= '0;
      fault_o     <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (!byte_i && (address_i[1:0] != 2'b00)) begin
              fault_o <= 1'b1;
            end else begin
              state       <= REQ;
              tmo_cnt     <= '0;
              is_load_q   <= load_i;
              is_byte_q   <= byte_i;
              lane_q      <= address_i[1:0];
              dest_q      <= dest_reg_i;
              mem_we_o    <= !load_i;
              mem_addr_o  <= {address_i[XLEN-1:2], 2'b00};
              mem_be_o    <= req_be;
              mem_wdata_o <= req_wdata;
            end
          end
        end
        REQ: begin
          // Ack is tested first so it wins over an expiring timeout.
          if (mem_ack_i) begin
            if (is_load_q) begin
              state      <= WB;
              wb_valid_o <= 1'b1;
              wb_reg_o   <= dest_q;
              wb_data_o  <= rsp_load;
            end else begin
              state <= IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            fault_o <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
